// File: rtl/attn_pkg.sv
// attn_pkg: shared Q-format constants and the dot-product FSM state type
package attn_pkg;

   localparam int Q_IN_INT   = 8;
   localparam int Q_IN_FRAC  = 8;
   localparam int Q_ACC_INT  = 18;
   localparam int Q_ACC_FRAC = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } dot_state_t;

endpackage

// File: rtl/fxp_mul.sv
// fxp_mul: combinational signed WIDTH x WIDTH -> 2*WIDTH multiplier
module fxp_mul #(
   parameter int WIDTH = 16
) (
   input  logic signed [WIDTH-1:0]   a,
   input  logic signed [WIDTH-1:0]   b,
   output logic signed [2*WIDTH-1:0] p
);

   assign p = a * b;

endmodule

// File: rtl/dot_product_acc.sv
// dot_product_acc: streaming Q8.8 x Q8.8 dot product into a Q18.16 result; DOT_PIPE_MUL_EN registers the product
module dot_product_acc
   import attn_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int VEC_LEN    = 4,
   parameter int ACC_WIDTH  = 34
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] a_in,
   input  logic [DATA_WIDTH-1:0] b_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ACC_WIDTH-1:0]  out_data
);

   localparam int CW = $clog2(VEC_LEN);
   localparam int PW = 2 * DATA_WIDTH;

   dot_state_t                  state;
   logic [CW-1:0]               cnt;
   logic signed [ACC_WIDTH-1:0] acc;
   logic signed [PW-1:0]        prod;
   logic signed [PW-1:0]        add_p;
   logic                        add_v;
   logic                        add_f;
   logic                        accept;
   logic                        last;

   fxp_mul #(.WIDTH(DATA_WIDTH)) u_mul (
      .a(a_in),
      .b(b_in),
      .p(prod)
   );

   assign accept   = in_valid && in_ready;
   assign last     = cnt == CW'(VEC_LEN - 1);
   assign out_data = acc;

`ifdef DOT_PIPE_MUL_EN
   logic signed [PW-1:0] prod_q;
   logic                 prod_v;
   logic                 prod_f;

   // product pipeline stage, tagged with whether it opens a new vector
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_q <= '0;
         prod_v <= 1'b0;
         prod_f <= 1'b0;
      end else if (clr) begin
         prod_q <= '0;
         prod_v <= 1'b0;
         prod_f <= 1'b0;
      end else begin
         prod_q <= accept ? prod : prod_q;
         prod_v <= accept;
         prod_f <= cnt == '0;
      end
   end

   assign add_p = prod_q;
   assign add_v = prod_v && !clr;
   assign add_f = prod_f;
`else
   assign add_p = prod;
   assign add_v = accept && !clr;
   assign add_f = cnt == '0;
`endif

   // first product of a vector loads the accumulator, later ones add to it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         acc <= '0;
      else if (add_v)
         acc <= add_f ? ACC_WIDTH'(add_p) : acc + ACC_WIDTH'(add_p);
   end

   // control FSM: element counting and registered handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
      end else if (clr) begin
         state     <= IDLE;
         cnt       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE, ACCUM: begin
               in_ready <= 1'b1;
               if (accept) begin
                  cnt <= cnt + 1'b1;
                  if (last) begin
`ifdef DOT_PIPE_MUL_EN
                     state     <= FLUSH;
`else
                     state     <= DONE;
                     out_valid <= 1'b1;
`endif
                     in_ready  <= 1'b0;
                  end else begin
                     state <= ACCUM;
                  end
               end
            end
            FLUSH: begin
               state     <= DONE;
               out_valid <= 1'b1;
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dot_product_acc.sv
// tb_dot_product_acc: scoreboard bench for dot_product_acc with directed vectors
module tb_dot_product_acc;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a_in = '0;
   logic [15:0] b_in = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [33:0] out_data;

   int checks = 0;
   int errors = 0;
   logic [33:0] exp_q[$];
   logic [33:0] held;

`ifdef DOT_PIPE_MUL_EN
   localparam bit PIPE = 1'b1;
`else
   localparam bit PIPE = 1'b0;
`endif

   dot_product_acc #(.DATA_WIDTH(16), .VEC_LEN(4), .ACC_WIDTH(34)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .clr(clr),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .a_in(a_in),
      .b_in(b_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // monitor: pop the scoreboard whenever a result handshake is about to happen
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got %h expected none", out_data);
         end else begin
            chk("result", {30'd0, out_data}, {30'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [15:0] a, input logic [15:0] b, input int gap);
      int t;
      repeat (gap) tick();
      in_valid = 1'b1;
      a_in = a;
      b_in = b;
      t = 0;
      while (!in_ready && t < 100) begin
         tick();
         t++;
      end
      if (t >= 100) chk("beat_timeout", 64'd1, 64'd0);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic send_vec(input logic [15:0] a [4], input logic [15:0] b [4],
                           input logic [33:0] exp, input int maxgap);
      exp_q.push_back(exp);
      for (int i = 0; i < 4; i++)
         beat(a[i], b[i], maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         tick();
         t++;
      end
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic wait_valid();
      int t;
      t = 0;
      while (!out_valid && t < 50) begin
         tick();
         t++;
      end
      chk("wait_valid", {63'd0, out_valid}, 64'd1);
   endtask

   logic [15:0] v1a [4] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
   logic [15:0] one [4] = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
   logic [15:0] neg [4] = '{16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00};
   logic [15:0] pmx [4] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
   logic [15:0] nmx [4] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
   logic [15:0] mxa [4] = '{16'h0180, 16'hFE00, 16'h0040, 16'h0000};
   logic [15:0] mxb [4] = '{16'h0200, 16'h0080, 16'hFC00, 16'h7FFF};

   localparam logic [33:0] R_V1  = 34'h0000A0000;
   localparam logic [33:0] R_NEG = 34'h3FFFC0000;
   localparam logic [33:0] R_PMX = 34'h0FFFC0004;
   localparam logic [33:0] R_NMX = 34'h100000000;
   localparam logic [33:0] R_MIX = 34'h000010000;

   initial begin
      #3;
      chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_data", {30'd0, out_data}, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
      out_ready = 1'b1;

      send_vec(v1a, one, R_V1, 0);
      chk("latency_first", {63'd0, out_valid}, PIPE ? 64'd0 : 64'd1);
      if (PIPE) begin
         tick();
         chk("latency_pipe", {63'd0, out_valid}, 64'd1);
      end
      send_vec(neg, one, R_NEG, 0);
      send_vec(pmx, pmx, R_PMX, 0);
      send_vec(nmx, nmx, R_NMX, 0);
      drain();

      out_ready = 1'b0;
      send_vec(mxa, mxb, R_MIX, 0);
      wait_valid();
      held = out_data;
      repeat (3) begin
         tick();
         chk("hold_data", {30'd0, out_data}, {30'd0, held});
         chk("hold_valid", {63'd0, out_valid}, 64'd1);
         chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
      end
      out_ready = 1'b1;
      tick();
      chk("release_out_valid", {63'd0, out_valid}, 64'd0);
      chk("release_in_ready", {63'd0, in_ready}, 64'd1);
      chk("release_popped", 64'(exp_q.size()), 64'd0);

      beat(neg[0], one[0], 0);
      beat(neg[1], one[1], 0);
      clr = 1'b1;
      in_valid = 1'b1;
      a_in = 16'h7FFF;
      b_in = 16'h7FFF;
      tick();
      clr = 1'b0;
      in_valid = 1'b0;
      chk("clr_in_ready", {63'd0, in_ready}, 64'd1);
      chk("clr_out_valid", {63'd0, out_valid}, 64'd0);
      send_vec(v1a, one, R_V1, 0);
      drain();

      for (int i = 0; i < 3; i++) beat(v1a[i], one[i], 0);
      clr = 1'b1;
      in_valid = 1'b1;
      a_in = v1a[3];
      b_in = one[3];
      tick();
      clr = 1'b0;
      in_valid = 1'b0;
      chk("clr_beat_dropped", {63'd0, out_valid}, 64'd0);
      tick();
      chk("clr_beat_dropped2", {63'd0, out_valid}, 64'd0);
      send_vec(mxa, mxb, R_MIX, 0);
      drain();

      beat(pmx[0], pmx[0], 0);
      beat(pmx[1], pmx[1], 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", {63'd0, in_ready}, 64'd0);
      chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("midrst_out_data", {30'd0, out_data}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("midrst_release", {63'd0, in_ready}, 64'd1);
      send_vec(mxa, mxb, R_MIX, 0);
      drain();

      send_vec(pmx, pmx, R_PMX, 3);
      send_vec(mxa, mxb, R_MIX, 3);
      drain();

      repeat (3) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
